// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute link: decode bundle, flush and handshakes in one place.
// Latency: none (wires only).
// Backpressure: in_ready_o throttles decode; out_ready_i throttles the pipe.
//
// Modports:
//   slave  - the pipe register (takes the *_i signals, drives the *_o signals)
//   master - the surrounding decode/ex logic or a bench (the opposite direction)
interface id_ex_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] inst_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [ADDR_W-1:0] op1_i;
  logic [ADDR_W-1:0] op2_i;
  logic [ADDR_W-1:0] op1_jump_i;
  logic [ADDR_W-1:0] op2_jump_i;
  logic [DATA_W-1:0] reg1_rdata_i;
  logic [DATA_W-1:0] reg2_rdata_i;
  logic              reg_we_i;
  logic [REG_AW-1:0] reg_waddr_i;
  logic              csr_we_i;
  logic [DATA_W-1:0] csr_rdata_i;
  logic [ADDR_W-1:0] csr_waddr_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [ADDR_W-1:0] op1_o;
  logic [ADDR_W-1:0] op2_o;
  logic [ADDR_W-1:0] op1_jump_o;
  logic [ADDR_W-1:0] op2_jump_o;
  logic [DATA_W-1:0] reg1_rdata_o;
  logic [DATA_W-1:0] reg2_rdata_o;
  logic              reg_we_o;
  logic [REG_AW-1:0] reg_waddr_o;
  logic              csr_we_o;
  logic [DATA_W-1:0] csr_rdata_o;
  logic [ADDR_W-1:0] csr_waddr_o;

  modport slave (
    input  flush_i, in_valid_i, inst_i, inst_addr_i, op1_i, op2_i,
           op1_jump_i, op2_jump_i, reg1_rdata_i, reg2_rdata_i,
           reg_we_i, reg_waddr_i, csr_we_i, csr_rdata_i, csr_waddr_i,
           out_ready_i,
    output in_ready_o, out_valid_o, inst_o, inst_addr_o, op1_o, op2_o,
           op1_jump_o, op2_jump_o, reg1_rdata_o, reg2_rdata_o,
           reg_we_o, reg_waddr_o, csr_we_o, csr_rdata_o, csr_waddr_o
  );

  modport master (
    output flush_i, in_valid_i, inst_i, inst_addr_i, op1_i, op2_i,
           op1_jump_i, op2_jump_i, reg1_rdata_i, reg2_rdata_i,
           reg_we_i, reg_waddr_i, csr_we_i, csr_rdata_i, csr_waddr_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, inst_addr_o, op1_o, op2_o,
           op1_jump_o, op2_jump_o, reg1_rdata_o, reg2_rdata_o,
           reg_we_o, reg_waddr_o, csr_we_o, csr_rdata_o, csr_waddr_o
  );
endinterface

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register with a main entry plus one skid entry.
// Latency: 1 cycle from accepted input to out_valid_o; 1 bundle/cycle sustained.
// Backpressure: in_ready_o = ~skid_valid, purely registered; ex stalls fill the skid.
//
// Ports:
//   clk          - clock
//   rst          - asynchronous active-low reset; discards both entries
//   bus (slave)  - decode bundle in, ex bundle out, flush_i, valid/ready pairs
//   stall_cnt_o  - 32-bit count of cycles with out_valid_o & ~out_ready_i
//                  (present only when ID_EX_STALL_CNT_EN is defined)
module id_ex_pipe #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       REG_AW   = 5,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h00000013)
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_pipe_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_addr;
    logic [ADDR_W-1:0] op1;
    logic [ADDR_W-1:0] op2;
    logic [ADDR_W-1:0] op1_jump;
    logic [ADDR_W-1:0] op2_jump;
    logic [DATA_W-1:0] reg1_rdata;
    logic [DATA_W-1:0] reg2_rdata;
    logic              reg_we;
    logic [REG_AW-1:0] reg_waddr;
    logic              csr_we;
    logic [DATA_W-1:0] csr_rdata;
    logic [ADDR_W-1:0] csr_waddr;
  } bundle_t;

  bundle_t in_b;
  bundle_t m_q, m_d;
  bundle_t s_q, s_d;
  bundle_t out_b;
  logic    m_vld_q, m_vld_d;
  logic    s_vld_q, s_vld_d;
  logic    in_xfer;
  logic    m_free;

  assign in_b = '{
    inst:       bus.inst_i,
    inst_addr:  bus.inst_addr_i,
    op1:        bus.op1_i,
    op2:        bus.op2_i,
    op1_jump:   bus.op1_jump_i,
    op2_jump:   bus.op2_jump_i,
    reg1_rdata: bus.reg1_rdata_i,
    reg2_rdata: bus.reg2_rdata_i,
    reg_we:     bus.reg_we_i,
    reg_waddr:  bus.reg_waddr_i,
    csr_we:     bus.csr_we_i,
    csr_rdata:  bus.csr_rdata_i,
    csr_waddr:  bus.csr_waddr_i
  };

  // Ready comes straight from the skid flag so there is no ex->decode comb path.
  assign bus.in_ready_o = ~s_vld_q;
  assign in_xfer        = bus.in_valid_i & ~s_vld_q;
  // M can take a new entry when it is empty or being consumed this cycle.
  assign m_free         = ~m_vld_q | bus.out_ready_i;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (bus.flush_i) begin
      // Squash everything, including a same-cycle input transfer.
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (m_free) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        // Unreachable while ready is ~s_vld, kept so S never drops a bundle
        // should ready ever be widened.
        if (in_xfer) begin
          s_d     = in_b;
          s_vld_d = 1'b1;
        end else begin
          s_vld_d = 1'b0;
        end
      end else if (in_xfer) begin
        m_d     = in_b;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      s_d     = in_b;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  // Outputs are masked to zero (NOP for the instruction) when M is empty.
  assign out_b            = m_vld_q ? m_q : '0;
  assign bus.out_valid_o  = m_vld_q;
  assign bus.inst_o       = m_vld_q ? m_q.inst : NOP_INST;
  assign bus.inst_addr_o  = out_b.inst_addr;
  assign bus.op1_o        = out_b.op1;
  assign bus.op2_o        = out_b.op2;
  assign bus.op1_jump_o   = out_b.op1_jump;
  assign bus.op2_jump_o   = out_b.op2_jump;
  assign bus.reg1_rdata_o = out_b.reg1_rdata;
  assign bus.reg2_rdata_o = out_b.reg2_rdata;
  assign bus.reg_we_o     = out_b.reg_we;
  assign bus.reg_waddr_o  = out_b.reg_waddr;
  assign bus.csr_we_o     = out_b.csr_we;
  assign bus.csr_rdata_o  = out_b.csr_rdata;
  assign bus.csr_waddr_o  = out_b.csr_waddr;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Free-running wrap; flush does not clear it, only reset does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (m_vld_q && !bus.out_ready_i) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  // {s_vld, m_vld} = 2'b10 would mean a skid entry with no main entry.
  a_no_skid_without_main : assert property (
    @(posedge clk) disable iff (!rst) !(s_vld_q && !m_vld_q)
  );

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, single bundle, streaming, backpressure,
// flush, asynchronous reset and (with ID_EX_STALL_CNT_EN) the stall counter.
module tb_id_ex_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst;
  int   vec;
  int   miss;

  id_ex_pipe_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) bus ();

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt;
  id_ex_pipe dut (.clk(clk), .rst(rst), .bus(bus), .stall_cnt_o(stall_cnt));
`else
  id_ex_pipe dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle; inputs are then driven and outputs read.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.flush_i      = 1'b0;
    bus.in_valid_i   = 1'b0;
    bus.inst_i       = '0;
    bus.inst_addr_i  = '0;
    bus.op1_i        = '0;
    bus.op2_i        = '0;
    bus.op1_jump_i   = '0;
    bus.op2_jump_i   = '0;
    bus.reg1_rdata_i = '0;
    bus.reg2_rdata_i = '0;
    bus.reg_we_i     = 1'b0;
    bus.reg_waddr_i  = '0;
    bus.csr_we_i     = 1'b0;
    bus.csr_rdata_i  = '0;
    bus.csr_waddr_i  = '0;
    bus.out_ready_i  = 1'b0;
  endtask

  task automatic send(input logic [31:0] addr, input logic [31:0] inst);
    bus.in_valid_i  = 1'b1;
    bus.inst_addr_i = addr;
    bus.inst_i      = inst;
    bus.reg_we_i    = 1'b1;
    bus.csr_we_i    = 1'b1;
    bus.reg_waddr_i = addr[6:2];
  endtask

  task automatic test_reset();
    clr_in();
    rst = 1'b0;
    #1;
    vec++; if (bus.out_valid_o !== 1'b0) begin miss++; $display("FAIL rst_out_valid got=%0h exp=0", bus.out_valid_o); end
    vec++; if (bus.in_ready_o !== 1'b1) begin miss++; $display("FAIL rst_in_ready got=%0h exp=1", bus.in_ready_o); end
    vec++; if (bus.inst_o !== NOP) begin miss++; $display("FAIL rst_inst got=%08h exp=%08h", bus.inst_o, NOP); end
    vec++; if ({bus.reg_we_o, bus.csr_we_o, bus.op2_o} !== 34'd0) begin miss++; $display("FAIL rst_data got=%0h exp=0", {bus.reg_we_o, bus.csr_we_o, bus.op2_o}); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.out_ready_i  = 1'b1;
    bus.in_valid_i   = 1'b1;
    bus.inst_i       = 32'h00A00093;
    bus.op1_i        = 32'd0;
    bus.op2_i        = 32'd10;
    bus.reg_we_i     = 1'b1;
    bus.reg_waddr_i  = 5'd1;
    bus.reg1_rdata_i = 32'hDEADBEEF;
    bus.csr_waddr_i  = 32'h00000300;
    step();
    clr_in();
    bus.out_ready_i = 1'b1;
    vec++; if (bus.out_valid_o !== 1'b1) begin miss++; $display("FAIL single_valid got=%0h exp=1", bus.out_valid_o); end
    vec++; if (bus.inst_o !== 32'h00A00093) begin miss++; $display("FAIL single_inst got=%08h exp=00a00093", bus.inst_o); end
    vec++; if (bus.op2_o !== 32'd10) begin miss++; $display("FAIL single_op2 got=%0d exp=10", bus.op2_o); end
    vec++; if (bus.reg_waddr_o !== 5'd1 || bus.reg_we_o !== 1'b1) begin miss++; $display("FAIL single_reg got=%0d/%0h exp=1/1", bus.reg_waddr_o, bus.reg_we_o); end
    vec++; if (bus.reg1_rdata_o !== 32'hDEADBEEF || bus.csr_waddr_o !== 32'h300) begin miss++; $display("FAIL single_side got=%08h/%0h exp=deadbeef/300", bus.reg1_rdata_o, bus.csr_waddr_o); end
    step();
    vec++; if (bus.out_valid_o !== 1'b0) begin miss++; $display("FAIL single_drain_valid got=%0h exp=0", bus.out_valid_o); end
    vec++; if (bus.inst_o !== NOP || bus.op2_o !== 32'd0 || bus.reg1_rdata_o !== 32'd0) begin miss++; $display("FAIL single_drain_mask got=%08h/%0h/%0h exp=00000013/0/0", bus.inst_o, bus.op2_o, bus.reg1_rdata_o); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'(i * 4), 32'h1000 + 32'(i));
      step();
      vec++; if (bus.in_ready_o !== 1'b1) begin miss++; $display("FAIL stream_ready[%0d] got=%0h exp=1", i, bus.in_ready_o); end
      vec++; if ({bus.out_valid_o, bus.inst_addr_o} !== {1'b1, 32'(i * 4)}) begin miss++; $display("FAIL stream_out[%0d] got=%0h/%0h exp=1/%0h", i, bus.out_valid_o, bus.inst_addr_o, i * 4); end
    end
    clr_in();
    bus.out_ready_i = 1'b1;
    step();
    vec++; if (bus.out_valid_o !== 1'b0) begin miss++; $display("FAIL stream_end_valid got=%0h exp=0", bus.out_valid_o); end
  endtask

  task automatic test_backpressure();
    clr_in();
    send(32'h100, 32'hA);
    step();
    vec++; if (bus.inst_addr_o !== 32'h100 || bus.in_ready_o !== 1'b1) begin miss++; $display("FAIL bp_a got=%0h/%0h exp=100/1", bus.inst_addr_o, bus.in_ready_o); end
    send(32'h104, 32'hB);
    step();
    vec++; if (bus.inst_addr_o !== 32'h100 || bus.in_ready_o !== 1'b0) begin miss++; $display("FAIL bp_full got=%0h/%0h exp=100/0", bus.inst_addr_o, bus.in_ready_o); end
    send(32'h1F0, 32'hF);
    bus.in_valid_i = 1'b0;
    step();
    vec++; if (bus.inst_addr_o !== 32'h100 || bus.inst_i === bus.inst_o || bus.out_valid_o !== 1'b1) begin miss++; $display("FAIL bp_hold got=%0h/%0h exp=100/1", bus.inst_addr_o, bus.out_valid_o); end
    bus.out_ready_i = 1'b1;
    step();
    vec++; if (bus.inst_addr_o !== 32'h104 || bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b1) begin miss++; $display("FAIL bp_b got=%0h/%0h exp=104/1", bus.inst_addr_o, bus.in_ready_o); end
    step();
    vec++; if (bus.out_valid_o !== 1'b0) begin miss++; $display("FAIL bp_drain got=%0h exp=0", bus.out_valid_o); end
  endtask

  task automatic test_flush();
    clr_in();
    send(32'h200, 32'hA);
    step();
    send(32'h204, 32'hB);
    step();
    send(32'h208, 32'hC);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    vec++; if (bus.out_valid_o !== 1'b0 || bus.reg_we_o !== 1'b0 || bus.csr_we_o !== 1'b0) begin miss++; $display("FAIL flush_full_out got=%0h/%0h/%0h exp=0/0/0", bus.out_valid_o, bus.reg_we_o, bus.csr_we_o); end
    vec++; if (bus.in_ready_o !== 1'b1 || bus.inst_o !== NOP) begin miss++; $display("FAIL flush_full_rdy got=%0h/%08h exp=1/00000013", bus.in_ready_o, bus.inst_o); end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if (bus.out_valid_o !== 1'b0) begin miss++; $display("FAIL flush_ghost[%0d] got=%0h addr=%0h exp=0", i, bus.out_valid_o, bus.inst_addr_o); end
    end
    // Flush with only M held and an accepted input in the same cycle.
    bus.out_ready_i = 1'b0;
    send(32'h300, 32'hA);
    step();
    send(32'h304, 32'hC);
    bus.flush_i = 1'b1;
    step();
    clr_in();
    bus.out_ready_i = 1'b1;
    vec++; if (bus.out_valid_o !== 1'b0) begin miss++; $display("FAIL flush_one got=%0h exp=0", bus.out_valid_o); end
    step();
    vec++; if (bus.out_valid_o !== 1'b0) begin miss++; $display("FAIL flush_drop_in got=%0h addr=%0h exp=0", bus.out_valid_o, bus.inst_addr_o); end
  endtask

  task automatic test_async_reset();
    clr_in();
    send(32'h400, 32'hA);
    step();
    send(32'h404, 32'hB);
    step();
    clr_in();
    vec++; if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1) begin miss++; $display("FAIL arst_pre got=%0h/%0h exp=0/1", bus.in_ready_o, bus.out_valid_o); end
    #2;
    rst = 1'b0;
    #1;
    vec++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin miss++; $display("FAIL arst_flags got=%0h/%0h exp=0/1", bus.out_valid_o, bus.in_ready_o); end
    vec++; if (bus.inst_o !== NOP || bus.inst_addr_o !== 32'd0 || bus.reg_we_o !== 1'b0) begin miss++; $display("FAIL arst_data got=%08h/%0h/%0h exp=00000013/0/0", bus.inst_o, bus.inst_addr_o, bus.reg_we_o); end
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready_i = 1'b1;
    step();
    vec++; if (bus.out_valid_o !== 1'b0) begin miss++; $display("FAIL arst_after got=%0h exp=0", bus.out_valid_o); end
  endtask

`ifdef ID_EX_STALL_CNT_EN
  task automatic test_stall_cnt();
    clr_in();
    vec++; if (stall_cnt !== 32'd0) begin miss++; $display("FAIL stall_init got=%0d exp=0", stall_cnt); end
    send(32'h500, 32'hA);
    step();
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    vec++; if (stall_cnt !== 32'd5 || bus.out_valid_o !== 1'b1) begin miss++; $display("FAIL stall_five got=%0d/%0h exp=5/1", stall_cnt, bus.out_valid_o); end
    bus.out_ready_i = 1'b1;
    bus.flush_i     = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    vec++; if (stall_cnt !== 32'd5) begin miss++; $display("FAIL stall_after_flush got=%0d exp=5", stall_cnt); end
  endtask
`endif

  initial begin
    vec  = 0;
    miss = 0;
    rst  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef ID_EX_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
